// File: rtl/regfile_writeback_ctrl_if.sv
// Write-back controller bundle: ALU results, load issue/return, decode hazard query, regfile write port.
// master = pipeline/memory side driving requests; slave = the write-back controller.
interface regfile_writeback_ctrl_if;
  logic        alu_valid;
  logic [4:0]  alu_index;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_index;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic [4:0]  rs_index;
  logic [4:0]  rt_index;
  logic        rs_busy;
  logic        rt_busy;
  logic [4:0]  wb_index;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        err_proto;

  modport master (
    output alu_valid, alu_index, alu_data, ld_issue, ld_index, mem_rvalid, mem_rdata,
           rs_index, rt_index,
    input  ld_ready, mem_rready, rs_busy, rt_busy, wb_index, wb_data, wb_we, err_proto
  );

  modport slave (
    input  alu_valid, alu_index, alu_data, ld_issue, ld_index, mem_rvalid, mem_rdata,
           rs_index, rt_index,
    output ld_ready, mem_rready, rs_busy, rt_busy, wb_index, wb_data, wb_we, err_proto
  );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Merges ALU results and in-order load returns onto the single regfile write port, 1-cycle registered.
// Loads stall via ld_ready (FIFO full / duplicate destination); responses stall via mem_rready (hold full).
module regfile_writeback_ctrl #(
  parameter int LD_DEPTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  regfile_writeback_ctrl_if.slave bus
);
  localparam int          PW       = $clog2(LD_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LD_DEPTH);

  logic [4:0]    fifo_q [LD_DEPTH];
  logic [4:0]    fifo_d [LD_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          hold_vld_q, hold_vld_d;
  logic [4:0]    hold_idx_q, hold_idx_d;
  logic [31:0]   hold_dat_q, hold_dat_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_idx_q, wb_idx_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic          err_q, err_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       ld_rdy;
  logic       rsp_rdy;
  logic       push;
  logic       pop;
  logic       resp_vld;
  logic       alu_win;
  logic [4:0] head_idx;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];
  assign ld_rdy     = !fifo_full && !((bus.ld_index != 5'd0) && pending_q[bus.ld_index]);
  assign rsp_rdy    = !fifo_empty && !hold_vld_q;
  assign push       = bus.ld_issue && ld_rdy;
  assign pop        = bus.mem_rvalid && rsp_rdy;
  // An index-0 load still pops its FIFO slot but never competes for the write port.
  assign resp_vld   = pop && (head_idx != 5'd0);
  assign alu_win    = bus.alu_valid && (bus.alu_index != 5'd0);

  assign bus.ld_ready   = ld_rdy;
  assign bus.mem_rready = rsp_rdy;
  assign bus.rs_busy    = (bus.rs_index != 5'd0) &&
                          (pending_q[bus.rs_index] || (wb_we_q && (wb_idx_q == bus.rs_index)));
  assign bus.rt_busy    = (bus.rt_index != 5'd0) &&
                          (pending_q[bus.rt_index] || (wb_we_q && (wb_idx_q == bus.rt_index)));
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_index   = wb_idx_q;
  assign bus.wb_data    = wb_dat_q;
  assign bus.err_proto  = err_q;

  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    pending_d  = pending_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;
    hold_dat_d = hold_dat_q;
    wb_we_d    = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_dat_d   = wb_dat_q;
    err_d      = err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = bus.ld_index;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (bus.ld_index != 5'd0) pending_d[bus.ld_index] = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (bus.mem_rvalid && fifo_empty) err_d = 1'b1;
    if (alu_win && pending_q[bus.alu_index]) err_d = 1'b1;

    // Hold can only be occupied when no response is accepted, so at most one load loses.
    if (alu_win) begin
      wb_we_d  = 1'b1;
      wb_idx_d = bus.alu_index;
      wb_dat_d = bus.alu_data;
      if (resp_vld) begin
        hold_vld_d = 1'b1;
        hold_idx_d = head_idx;
        hold_dat_d = bus.mem_rdata;
      end
    end else if (hold_vld_q) begin
      wb_we_d               = 1'b1;
      wb_idx_d              = hold_idx_q;
      wb_dat_d              = hold_dat_q;
      hold_vld_d            = 1'b0;
      pending_d[hold_idx_q] = 1'b0;
    end else if (resp_vld) begin
      wb_we_d             = 1'b1;
      wb_idx_d            = head_idx;
      wb_dat_d            = bus.mem_rdata;
      pending_d[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LD_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
      hold_dat_q <= '0;
      wb_we_q    <= 1'b0;
      wb_idx_q   <= '0;
      wb_dat_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
      hold_dat_q <= hold_dat_d;
      wb_we_q    <= wb_we_d;
      wb_idx_q   <= wb_idx_d;
      wb_dat_q   <= wb_dat_d;
      err_q      <= err_d;
    end
  end
endmodule
